mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 25 ++
 rtl/byte_lane_merge.sv | 21 ++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and sizing for the memory access unit.
package mem_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    OP_LDR  = 2'b00,
    OP_STR  = 2'b01,
    OP_LDRB = 2'b10,
    OP_STRB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Word ops need a 4-byte aligned address.
  function automatic logic is_word_op(op_e op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane extraction (zero-extended, little-endian) and byte insertion into a word.
module byte_lane_merge (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] lane_byte,
  output logic [31:0] merged
);

  always_comb begin
    lane_byte = '0;
    merged    = word;
    case (lane)
      2'd0: begin lane_byte[7:0] = word[7:0];   merged[7:0]   = byte_in; end
      2'd1: begin lane_byte[7:0] = word[15:8];  merged[15:8]  = byte_in; end
      2'd2: begin lane_byte[7:0] = word[23:16]; merged[23:16] = byte_in; end
      default: begin lane_byte[7:0] = word[31:24]; merged[31:24] = byte_in; end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request channel and an external word memory
// with a combinational read port; byte stores are read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write_enable,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic [31:0] read_addr,
  input  logic [31:0] read_data
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [29:0] idx_q;
  logic [1:0]  lane_q;
  logic [31:0] wword_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_err;
  logic [31:0] lane_byte;
  logic [31:0] merged;

  assign req_err = (32'(req_addr[31:2]) >= MEM_WORDS) ||
                   (is_word_op(op_e'(req_op)) && (req_addr[1:0] != 2'b00));

  byte_lane_merge u_lane (
    .word      (read_data),
    .lane      (lane_q),
    .byte_in   (wword_q[7:0]),
    .lane_byte (lane_byte),
    .merged    (merged)
  );

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    mem_write_enable = 1'b0;
    write_addr       = '0;
    write_data       = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                      state_d = RESP;
          else if (op_e'(req_op) == OP_STR) state_d = WR;
          else                              state_d = RD;
        end
      end
      RD: state_d = (op_q == OP_STRB) ? WR : RESP;
      WR: begin
        mem_write_enable = ~rst;
        write_addr       = {2'b00, idx_q};
        write_data       = wword_q;
        state_d          = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // wword_q holds the store data from acceptance; a byte store replaces it
  // with the merged word during RD, so WR always writes wword_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LDR;
      idx_q   <= '0;
      lane_q  <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          op_q    <= op_e'(req_op);
          idx_q   <= req_addr[31:2];
          lane_q  <= req_addr[1:0];
          wword_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= req_err;
        end
        RD: begin
          if (op_q == OP_LDR)       rdata_q <= read_data;
          else if (op_q == OP_LDRB) rdata_q <= lane_byte;
          else                      wword_q <= merged;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign read_addr = {2'b00, idx_q};

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic against a
// transaction-level model (latency counts and a reference memory image).
module tb_mem_access_unit;

  localparam logic [1:0] LDR = 2'b00, STR = 2'b01, LDRB = 2'b10, STRB = 2'b11;
  localparam int unsigned NW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_write_enable;
  logic [31:0] write_addr, write_data, read_addr, read_data;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write_enable(mem_write_enable), .write_addr(write_addr),
    .write_data(write_data), .read_addr(read_addr), .read_data(read_data)
  );

  // External memory seen by the DUT, and the model's own image of it.
  logic [31:0] mem_arr [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];

  assign read_data = (read_addr < NW) ? mem_arr[read_addr[9:0]] : 32'hDEAD_BEEF;

  always @(posedge clk)
    if (mem_write_enable && write_addr < NW) mem_arr[write_addr[9:0]] = write_data;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: p counts cycles since the accept edge; response
  // shows at p==lat_m, the write (if any) happens during cycle p==wr_at.
  bit          busy = 0;
  int          p = 0, lat_m = 0, wr_at = 0;
  logic [29:0] m_idx = '0, last_idx = '0;
  logic [31:0] m_rdata = '0, m_wword = '0;
  logic        m_err = 1'b0;
  int unsigned w, lane;

  always @(posedge clk) begin
    if (rst) begin
      busy = 0; p = 0; wr_at = 0; last_idx = '0;
    end else if (!busy) begin
      if (req_valid) begin
        w = 32'(req_addr >> 2);
        lane = 32'(req_addr & 32'h3);
        m_err = (w >= NW) || ((req_op == LDR || req_op == STR) && lane != 0);
        m_idx = req_addr[31:2];
        last_idx = req_addr[31:2];
        m_rdata = '0;
        wr_at = 0;
        if (m_err) lat_m = 1;
        else case (req_op)
          LDR:  begin m_rdata = ref_mem[w]; lat_m = 2; end
          LDRB: begin m_rdata = (ref_mem[w] >> (8 * lane)) & 32'hFF; lat_m = 2; end
          STR:  begin m_wword = req_wdata; wr_at = 1; lat_m = 2; end
          default: begin
            m_wword = (ref_mem[w] & ~(32'hFF << (8 * lane))) | ((req_wdata & 32'hFF) << (8 * lane));
            wr_at = 2; lat_m = 3;
          end
        endcase
        busy = 1; p = 1;
      end
    end else begin
      if (wr_at != 0 && p == wr_at) ref_mem[m_idx[9:0]] = m_wword;
      if (p >= lat_m) begin
        if (rsp_ready) busy = 0;
      end else p++;
    end
  end

  // Per-cycle comparison against the model.
  logic exp_we;
  always @(negedge clk) begin
    exp_we = busy && wr_at != 0 && p == wr_at;
    chk("req_ready", 32'(req_ready), 32'(!busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(busy && p == lat_m));
    if (busy && p == lat_m) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    chk("mem_write_enable", 32'(mem_write_enable), 32'(exp_we && !rst));
    chk("write_addr", write_addr, exp_we ? {2'b00, m_idx} : 32'h0);
    chk("write_data", write_data, exp_we ? m_wword : 32'h0);
    chk("read_addr", read_addr, {2'b00, last_idx});
  end

  int          wr_cnt = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  always @(negedge clk)
    if (mem_write_enable) begin
      wr_cnt++; last_wa = write_addr; last_wd = write_data;
    end

  // One request with literal expectations; entered at posedge+1 with the unit idle.
  // While busy, a junk STR is kept on the request channel to show it is ignored.
  task automatic txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input int hold, input logic [31:0] exp_rd, input logic exp_er,
                     input int exp_lat);
    int n, lat;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_op = STR; req_addr = 32'h40; req_wdata = 32'hBAD;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("txn_rdata", rsp_rdata, exp_rd);
    chk("txn_err", 32'(rsp_err), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(exp_er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_we"}, 32'(mem_write_enable), 32'd0);
    chk({tag, "_write_addr"}, write_addr, 32'd0);
    chk({tag, "_write_data"}, write_data, 32'd0);
    chk({tag, "_read_addr"}, read_addr, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int w0, bad;
    logic [31:0] v, a;
    int unsigned r;
    for (int i = 0; i < int'(NW); i++) begin
      v = $urandom; mem_arr[i] = v; ref_mem[i] = v;
    end
    mem_arr[10] = 32'h0000_000A; ref_mem[10] = 32'h0000_000A;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    w0 = wr_cnt;
    txn(LDR, 32'h28, 32'h0, 0, 32'h0000_000A, 1'b0, 2);
    chk("ldr_no_write", 32'(wr_cnt), 32'(w0));

    w0 = wr_cnt;
    txn(STR, 32'h30, 32'h1E, 0, 32'h0, 1'b0, 2);
    chk("str_write_count", 32'(wr_cnt), 32'(w0 + 1));
    chk("str_write_addr", last_wa, 32'd12);
    chk("str_write_data", last_wd, 32'h1E);
    txn(LDR, 32'h30, 32'h0, 0, 32'h1E, 1'b0, 2);

    w0 = wr_cnt;
    txn(STRB, 32'h29, 32'hAB, 0, 32'h0, 1'b0, 3);
    chk("strb_write_count", 32'(wr_cnt), 32'(w0 + 1));
    chk("strb_write_addr", last_wa, 32'd10);
    chk("strb_write_data", last_wd, 32'h0000_AB0A);
    txn(LDRB, 32'h29, 32'h0, 0, 32'hAB, 1'b0, 2);

    w0 = wr_cnt;
    txn(LDR, 32'h2A, 32'h0, 0, 32'h0, 1'b1, 1);
    txn(STR, 32'h1000, 32'h77, 0, 32'h0, 1'b1, 1);
    txn(LDRB, 32'h1001, 32'h0, 0, 32'h0, 1'b1, 1);
    chk("err_no_write", 32'(wr_cnt), 32'(w0));

    txn(LDR, 32'h28, 32'h0, 3, 32'h0000_AB0A, 1'b0, 2);
    txn(LDR, 32'hFFC, 32'h0, 0, ref_mem[1023], 1'b0, 2);

    // Reset while the STR sits in its write cycle.
    req_valid = 1'b1; req_op = STR; req_addr = 32'h30; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr_cycle_we", 32'(mem_write_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("wr_we_gated", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("midwr");
    chk("midwr_mem12", mem_arr[12], 32'h1E);
    @(posedge clk); #1;
    txn(LDR, 32'h30, 32'h0, 0, 32'h1E, 1'b0, 2);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = $urandom;
      else if (r < 3)  a = ((1020 + $urandom_range(0, 7)) << 2) | $urandom_range(0, 3);
      else             a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      req_addr  = a;
      req_op    = 2'($urandom_range(0, 3));
      req_wdata = $urandom;
      req_valid = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    bad = 0;
    for (int i = 0; i < int'(NW); i++) if (mem_arr[i] !== ref_mem[i]) bad++;
    chk("mem_image", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
